// File: rtl/dtu_req_splitter_pkg.sv
// Shared DTU request types: descriptor layout, splitter state encoding and defaults.
package dtu_req_splitter_pkg;

    localparam int VADDR_BITS        = 48;
    localparam int LEN_BITS          = 28;
    localparam int DTU_XFER_BITS_DEF = 12;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic                  last;
        logic [5:0]            pid;
        logic [3:0]            dest;
        logic [1:0]            strm;
        logic                  actv;
        logic                  host;
    } req_t;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SPLIT
    } dtu_split_state_t;

endpackage

// File: rtl/dtu_req_splitter_chunk_calc.sv
// Combinational chunk sizing: bytes left before the next 2^XFER_BITS boundary,
// clipped to the remaining length.
module dtu_chunk_calc
    import dtu_req_splitter_pkg::*;
#(
    parameter int XFER_BITS = DTU_XFER_BITS_DEF
) (
    input  logic [XFER_BITS-1:0] i_vaddr_off,
    input  logic [LEN_BITS-1:0]  i_len,
    output logic [LEN_BITS-1:0]  o_chunk_len,
    output logic                 o_is_final
);

    localparam logic [LEN_BITS-1:0] XFER_SIZE = LEN_BITS'(1) << XFER_BITS;

    logic [LEN_BITS-1:0] w_room;

    always_comb begin
        w_room      = XFER_SIZE - {{(LEN_BITS-XFER_BITS){1'b0}}, i_vaddr_off};
        o_chunk_len = (i_len < w_room) ? i_len : w_room;
        o_is_final  = (o_chunk_len == i_len);
    end

endmodule

// File: rtl/dtu_req_splitter.sv
// Splits request descriptors into chunks that never exceed nor cross a
// 2^XFER_BITS-byte aligned window; one registered chunk per cycle.
module dtu_req_splitter
    import dtu_req_splitter_pkg::*;
#(
    parameter int XFER_BITS = DTU_XFER_BITS_DEF
) (
    input  logic aclk,
    input  logic areset,
    input  logic s_req_valid,
    output logic s_req_ready,
    input  req_t s_req_data,
    output logic m_req_valid,
    input  logic m_req_ready,
    output req_t m_req_data,
    output logic busy
);

    dtu_split_state_t r_state;
    logic             r_m_valid;
    req_t             r_m_data;
    // Remaining address/length of the descriptor being split, plus its
    // pass-through fields and original last flag.
    req_t             r_cur;

    logic                  w_free;
    logic                  w_accept;
    logic [VADDR_BITS-1:0] w_vaddr;
    logic [LEN_BITS-1:0]   w_len;
    logic [LEN_BITS-1:0]   w_chunk;
    logic                  w_is_final;
    logic [VADDR_BITS-1:0] w_next_vaddr;

    always_comb begin
        w_free       = !r_m_valid || m_req_ready;
        s_req_ready  = !areset && (r_state == ST_IDLE) && w_free;
        w_accept     = s_req_valid && s_req_ready;
        w_vaddr      = (r_state == ST_IDLE) ? s_req_data.vaddr : r_cur.vaddr;
        w_len        = (r_state == ST_IDLE) ? s_req_data.len   : r_cur.len;
        w_next_vaddr = w_vaddr + {{(VADDR_BITS-LEN_BITS){1'b0}}, w_chunk};
    end

    dtu_chunk_calc #(
        .XFER_BITS(XFER_BITS)
    ) u_chunk_calc (
        .i_vaddr_off(w_vaddr[XFER_BITS-1:0]),
        .i_len      (w_len),
        .o_chunk_len(w_chunk),
        .o_is_final (w_is_final)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_cur     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_m_valid     <= 1'b1;
                        r_m_data      <= s_req_data;
                        r_m_data.len  <= w_chunk;
                        r_m_data.last <= w_is_final && s_req_data.last;
                        if (!w_is_final) begin
                            r_cur       <= s_req_data;
                            r_cur.vaddr <= w_next_vaddr;
                            r_cur.len   <= s_req_data.len - w_chunk;
                            r_state     <= ST_SPLIT;
                        end
                    end else if (m_req_ready) begin
                        r_m_valid <= 1'b0;
                    end
                end
                ST_SPLIT: begin
                    if (w_free) begin
                        r_m_valid     <= 1'b1;
                        r_m_data      <= r_cur;
                        r_m_data.len  <= w_chunk;
                        r_m_data.last <= w_is_final && r_cur.last;
                        r_cur.vaddr   <= w_next_vaddr;
                        r_cur.len     <= r_cur.len - w_chunk;
                        if (w_is_final) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_req_valid = r_m_valid;
    assign m_req_data  = r_m_data;
    assign busy        = (r_state == ST_SPLIT) || r_m_valid;

endmodule

// File: doc/dtu_req_splitter.md
Name: dtu_req_splitter

Overview:
- Sits in the DTU between the local request arbiter output (local_sq_rd / local_sq_wr) and the host credit stage.
- Splits each req_t descriptor into chunks. No chunk exceeds 2^XFER_BITS bytes, and no chunk crosses a 2^XFER_BITS-aligned address boundary.
- This bounds the credit accounting and DMA bypass transfer size downstream.
- One instance per direction (rd, wr).

Parameters:
- XFER_BITS, 12: log2 of the maximum chunk size and of the alignment boundary (4 KiB). Legal range 6..LEN_BITS-1.

Ports:
- aclk, in, 1: clock.
- areset, in, 1: synchronous, active-high reset.
- s_req_valid, in, 1: input descriptor valid.
- s_req_ready, out, 1: input descriptor accepted.
- s_req_data, in, req_t: input descriptor; uses fields vaddr, len, last; all other fields are passed through.
- m_req_valid, out, 1: chunk descriptor valid (registered).
- m_req_ready, in, 1: downstream accepts chunk.
- m_req_data, out, req_t: chunk descriptor (registered).
- busy, out, 1: asserted while a descriptor is being split or a chunk is pending.

Behaviour:
- Reset (areset=1 at a rising edge):
  - state <= ST_IDLE, m_req_valid <= 0, m_req_data <= '0, busy <= 0.
  - s_req_ready is forced 0 while areset is high.
- Output register "free" means !m_req_valid || m_req_ready.
- s_req_ready = !areset && state==ST_IDLE && free. This is combinational from m_req_ready; there is no path from s_req_valid to s_req_ready.
- Chunk length computation: off = vaddr[XFER_BITS-1:0].
  - chunk = min(rem_len, 2^XFER_BITS - off).
  - Computed in LEN_BITS-wide unsigned arithmetic; the constant 2^XFER_BITS needs XFER_BITS+1 bits.
- ST_IDLE, on accept (s_req_valid && s_req_ready):
  - Load m_req_data from s_req_data with len=chunk and vaddr=s.vaddr. Set m_req_valid <= 1.
  - If chunk == s.len: last = s.last and stay in ST_IDLE.
  - Otherwise: last = 0; store cur_vaddr = s.vaddr+chunk, cur_len = s.len-chunk and the other fields; go to ST_SPLIT.
- ST_SPLIT, when free:
  - Emit the next chunk: vaddr=cur_vaddr, len=min(cur_len, 2^XFER_BITS). Addresses are now aligned.
  - Update cur_vaddr += len and cur_len -= len.
  - Final chunk (len==cur_len): last = original last, go to ST_IDLE. Otherwise last=0.
- Throughput: one chunk per cycle while m_req_ready=1. A new descriptor is accepted in the same cycle the final chunk is consumed, so back-to-back descriptors leave no bubble.
- Latency: accept at edge N → m_req_valid high after edge N; first chunk visible in cycle N+1.
- Backpressure: while m_req_valid && !m_req_ready, m_req_data and the internal counters hold stable.
- len == 0: forwarded as a single chunk, len 0, last unchanged; no split.
- vaddr addition wraps modulo 2^VADDR_BITS; there is no error signalling.
- Pass-through fields (pid, dest, strm, actv, host, etc.) are copied identically to every chunk.
- busy = (state==ST_SPLIT) || m_req_valid.
- Reset mid-split: pending and remaining chunks are discarded. The next cycle has m_req_valid=0 and state=ST_IDLE. The upstream descriptor is not replayed.

Decomposition:
- lynxTypes (shared package):
  - req_t, VADDR_BITS, LEN_BITS already live here.
  - Add typedef enum logic[0:0] {ST_IDLE, ST_SPLIT} dtu_split_state_t.
  - Add DTU_XFER_BITS_DEF = 12.
- One combinational sub-module, dtu_chunk_calc: inputs vaddr, len; outputs chunk_len and is_final. It is instantiated once and shared by both states.

Test Plan:
1. vaddr=0x1000, len=0x1000, last=1, m_req_ready=1 → one chunk {0x1000, 0x1000, last=1} in cycle N+1; s_req_ready stays high.
2. vaddr=0x0F00, len=0x300, last=1 → {0x0F00, 0x100, last=0} then {0x1000, 0x200, last=1} on consecutive cycles.
3. vaddr=0x0, len=0x2800, last=1 → {0x0,0x1000,0}, {0x1000,0x1000,0}, {0x2000,0x800,1} in 3 cycles. s_req_ready is low until the final chunk handshake; a second queued descriptor is accepted in that same cycle.
4. Same as case 3 with m_req_ready=0 for 5 cycles after the first chunk → second chunk held bit-stable for 5 cycles; no drop or duplicate; pid/dest identical on all chunks.
5. len=0, last=0 → one chunk {vaddr, 0, last=0}; busy deasserts the cycle after the handshake.
6. areset=1 during the 2nd chunk of case 3 → next cycle m_req_valid=0, busy=0, s_req_ready=0 while reset is held; after release, a new descriptor is split correctly from a clean state.
